delay_measure_sequencer: RTL and testbench

DELAY_MEASURE_SEQUENCER -- requirements
Module: delay_measure_sequencer

---
 rtl/delay_line_pkg.sv | 11 +
 rtl/sync_2ff.sv | 13 +
 rtl/delay_measure_sequencer.sv | 86 ++++++++
 tb/tb_delay_measure_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
// delay_line_pkg: shared states and byte codes for the delay measurement sequencer
package delay_line_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_FIRE, S_WAIT_ECHO, S_TX_STATUS, S_TX_HI, S_TX_LO, S_TX_NAK
    } state_t;
    localparam logic [7:0] CMD_MEASURE = 8'h4D;
    localparam logic [7:0] NAK_BYTE    = 8'h3F;
    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_TIMEOUT  = 8'h01;
    localparam logic [7:0] ST_STUCK    = 8'h02;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic r_meta, r_sync;
    always_ff @(posedge clk or posedge reset)
        if (reset) {r_sync, r_meta} <= 2'b00;
        else       {r_sync, r_meta} <= {r_meta, d};
    assign q = r_sync;
endmodule

// File: rtl/delay_measure_sequencer.sv
// delay_measure_sequencer: fires a pulse into a delay line on 'M' and reports the echo latency over UART bytes
module delay_measure_sequencer
    import delay_line_pkg::*;
#(
    parameter int          PULSE_LEN = 4,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       pulse_out,
    input  logic       echo_in,
    output logic       busy
);
    localparam logic [15:0] PL_LAST = 16'(PULSE_LEN - 1);
    state_t      r_state, w_next;
    logic [15:0] r_cnt, w_cnt, r_count, w_count;
    logic [7:0]  r_status, w_status;
    logic        r_pulse, w_echo_s, w_accept;
    sync_2ff u_sync (.clk(clk), .reset(reset), .d(echo_in), .q(w_echo_s));
    assign w_accept = tx_valid && tx_ready;
    always_comb begin
        w_next   = r_state;
        w_cnt    = r_cnt;
        w_count  = r_count;
        w_status = r_status;
        case (r_state)
            S_IDLE: if (rx_valid) begin
                w_next = rx_data == CMD_MEASURE ? S_ARM : S_TX_NAK;
                w_cnt  = 16'd0;
            end
            S_ARM: if (!w_echo_s) begin
                w_next = S_FIRE;
                w_cnt  = 16'd0;
            end else if (r_cnt == TIMEOUT) begin
                w_next   = S_TX_STATUS;
                w_status = ST_STUCK;
                w_count  = TIMEOUT;
            end else w_cnt = r_cnt + 16'd1;
            S_FIRE, S_WAIT_ECHO: if (w_echo_s) begin
                w_next   = S_TX_STATUS;
                w_status = ST_OK;
                w_count  = r_cnt;
            end else if (r_cnt == TIMEOUT) begin
                w_next   = S_TX_STATUS;
                w_status = ST_TIMEOUT;
                w_count  = TIMEOUT;
            end else begin
                w_cnt  = r_cnt + 16'd1;
                w_next = r_state == S_FIRE && r_cnt == PL_LAST ? S_WAIT_ECHO : r_state;
            end
            S_TX_STATUS: w_next = w_accept ? S_TX_HI : S_TX_STATUS;
            S_TX_HI:     w_next = w_accept ? S_TX_LO : S_TX_HI;
            S_TX_LO:     w_next = w_accept ? S_IDLE : S_TX_LO;
            S_TX_NAK:    w_next = w_accept ? S_IDLE : S_TX_NAK;
            default:     w_next = S_IDLE;
        endcase
    end
    // pulse is registered from the next state so it is glitch-free and cleared by reset
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 16'd0;
            r_count  <= 16'd0;
            r_status <= 8'd0;
            r_pulse  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt;
            r_count  <= w_count;
            r_status <= w_status;
            r_pulse  <= w_next == S_FIRE;
        end
    assign pulse_out = r_pulse;
    assign busy      = r_state != S_IDLE;
    assign tx_valid  = r_state == S_TX_STATUS || r_state == S_TX_HI ||
                       r_state == S_TX_LO || r_state == S_TX_NAK;
    assign tx_data   = r_state == S_TX_STATUS ? r_status :
                       r_state == S_TX_HI     ? r_count[15:8] :
                       r_state == S_TX_LO     ? r_count[7:0] :
                       r_state == S_TX_NAK    ? NAK_BYTE : 8'h00;
endmodule

// File: tb/tb_delay_measure_sequencer.sv
// tb_delay_measure_sequencer: randomized scoreboard bench against a latency reference model
module tb_delay_measure_sequencer;
    localparam int          PL    = 4;
    localparam logic [15:0] TMO   = 16'h0100;
    localparam int          NONE  = -1;
    localparam int          STUCK = -2;
    logic       clk = 0, reset = 0, rx_valid = 0, tx_ready = 0, echo_in = 0;
    logic [7:0] rx_data = 0;
    logic [7:0] tx_data;
    logic       tx_valid, pulse_out, busy;
    int         vectors = 0, miscompares = 0;
    logic [7:0] exp_q[$];
    int         pulse_widths[$];
    int         run_len = 0;
    int         mode = 1;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 0;
    delay_measure_sequencer #(.PULSE_LEN(PL), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .pulse_out(pulse_out), .echo_in(echo_in), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        #2;
        tx_ready = mode == 2 ? 1'b0 : mode == 1 ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
    always @(negedge clk) begin
        if (pulse_out) run_len++;
        else if (run_len > 0) begin
            pulse_widths.push_back(run_len);
            run_len = 0;
        end
        if (prev_stall) begin
            check("hold_valid", int'(tx_valid), 1);
            check("hold_data", int'(tx_data), int'(prev_data));
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check("unexpected_byte", int'(tx_data), -1);
            else check("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1;
        tick;
        rx_valid = 0;
    endtask
    task automatic wait_idle;
        int n = 0;
        while (busy && n < 2000) begin
            tick;
            n++;
        end
        check("idle_reached", int'(busy), 0);
    endtask
    task automatic wait_pulse;
        int n = 0;
        while (!pulse_out && n < 20) begin
            tick;
            n++;
        end
        check("pulse_rise", int'(pulse_out), 1);
    endtask
    // latency seen by the block = echo delay + 2 synchronizer cycles
    task automatic model(input int d, output logic [7:0] b[3], output int pw);
        int c;
        if (d == STUCK) begin
            b  = '{8'h02, TMO[15:8], TMO[7:0]};
            pw = 0;
        end else if (d < 0 || d + 2 > int'(TMO)) begin
            b  = '{8'h01, TMO[15:8], TMO[7:0]};
            pw = PL;
        end else begin
            c  = d + 2;
            b  = '{8'h00, 8'(c >> 8), 8'(c)};
            pw = d + 3 < PL ? d + 3 : PL;
        end
    endtask
    task automatic run_measure(input int d, input bit second_m, input bit stall);
        logic [7:0] b[3];
        int pw, n, saved;
        saved = mode;
        model(d, b, pw);
        foreach (b[i]) exp_q.push_back(b[i]);
        if (stall) mode = 2;
        if (d == STUCK) begin
            echo_in = 1;
            repeat (3) tick;
        end
        pulse_widths.delete();
        send(8'h4D);
        if (d != STUCK) begin
            wait_pulse;
            if (d >= 0) begin
                for (int i = 0; i < d; i++) begin
                    tick;
                    if (second_m && i == 6) begin
                        rx_data  = 8'h4D;
                        rx_valid = 1;
                    end
                    if (i == 7) rx_valid = 0;
                end
                echo_in = 1;
            end
        end
        if (stall) begin
            n = 0;
            while (!tx_valid && n < 2000) begin
                tick;
                n++;
            end
            mode = 1;
            tick;
            mode = 2;
            for (int i = 0; i < 20; i++) begin
                tick;
                check("stall_valid", int'(tx_valid), 1);
                check("stall_data", int'(tx_data), int'(b[1]));
            end
            mode = 1;
        end
        wait_idle;
        mode = saved;
        echo_in = 0;
        check("pulse_count", pulse_widths.size(), pw > 0 ? 1 : 0);
        if (pw > 0 && pulse_widths.size() > 0) check("pulse_width", pulse_widths[0], pw);
        repeat (4) tick;
        check("stays_idle", int'(busy), 0);
    endtask
    task automatic run_nak(input logic [7:0] b);
        exp_q.push_back(8'h3F);
        send(b);
        wait_idle;
        repeat (2) tick;
    endtask
    initial begin
        logic seen;
        logic [7:0] nb;
        int r, d;
        #1 reset = 1;
        #1;
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pulse", int'(pulse_out), 0);
        repeat (3) tick;
        reset = 0;
        tick;
        mode = 1;
        run_measure(10, 0, 0);
        run_measure(NONE, 0, 0);
        run_measure(STUCK, 0, 0);
        run_nak(8'h58);
        run_measure(20, 1, 0);
        run_measure(200, 0, 1);
        send(8'h4D);
        wait_pulse;
        tick;
        reset = 1;
        #1;
        check("midrst_pulse", int'(pulse_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(tx_valid), 0);
        repeat (2) tick;
        reset = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            seen |= tx_valid | busy | pulse_out;
        end
        check("post_rst_quiet", int'(seen), 0);
        pulse_widths.delete();
        run_measure(10, 0, 0);
        run_measure(int'(TMO) - 2, 0, 0);
        run_measure(int'(TMO) - 1, 0, 0);
        mode = 0;
        run_measure(1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                nb = 8'($urandom_range(0, 255));
                if (nb == 8'h4D) nb = 8'h58;
                run_nak(nb);
            end else if (r == 1) run_measure(NONE, 0, 0);
            else begin
                d = $urandom_range(1, 300);
                run_measure(d, d > 8 && $urandom_range(0, 1) == 1, 0);
            end
        end
        repeat (5) tick;
        check("leftover_bytes", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
